// File: rtl/router_wrap_odata_fifo.sv
// router_wrap_odata_fifo: WIDTH x DEPTH elastic output-data FIFO, valid/ready both sides,
// count/full/empty status and synchronous flush. Optional bypass via ROUTER_ODATA_BYPASS_EN.
// Ports: clk, reset (async active-low), flush, in_valid/in_ready/in_data,
//        out_valid/out_ready/out_data, count, full, empty.
module router_wrap_odata_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic             bypass;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;

`ifdef ROUTER_ODATA_BYPASS_EN
  // Empty FIFO with a ready consumer: hand the beat straight through
  // without touching storage, pointers or count.
  assign bypass    = empty && in_valid && out_ready;
  assign out_valid = !empty || bypass;
  assign out_data  = bypass ? in_data : mem[rd_ptr];
`else
  assign bypass    = 1'b0;
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr];
`endif

  assign push = in_valid && in_ready && !bypass;
  assign pop  = !empty && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      // Storage is left as-is; empty masks it.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_router_wrap_odata_fifo.sv
// tb_router_wrap_odata_fifo: directed + random stimulus against a queue model
// of the output-data FIFO.
module tb_router_wrap_odata_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] q [$];

  always #5 clk = ~clk;

  router_wrap_odata_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .count(count),
    .full(full),
    .empty(empty)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".count"}, 32'(count), 32'd0);
    check({tag, ".empty"}, 32'(empty), 32'd1);
    check({tag, ".full"}, 32'(full), 32'd0);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".out_data"}, out_data, 32'd0);
  endtask

  // One cycle: drive at negedge, check just after, update model for the
  // coming rising edge.
  task automatic step(input logic v, input logic [31:0] d,
                      input logic r, input logic f);
    int  size;
    bit  byp;
    bit  do_pop;
    bit  do_push;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    #1;
    size = q.size();
`ifdef ROUTER_ODATA_BYPASS_EN
    byp = (size == 0) && v && r;
`else
    byp = 1'b0;
`endif
    check("count", 32'(count), 32'(size));
    check("empty", 32'(empty), 32'(size == 0));
    check("full", 32'(full), 32'(size == DEPTH));
    check("in_ready", 32'(in_ready), 32'(size != DEPTH));
    check("out_valid", 32'(out_valid), 32'((size != 0) || byp));
    if (byp) check("out_data_byp", out_data, d);
    else if (size != 0) check("out_data", out_data, q[0]);
    if (f) begin
      q.delete();
    end else begin
      do_pop  = (size != 0) && r;
      do_push = v && (size != DEPTH) && !byp;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(d);
    end
  endtask

  initial begin
    // Reset then idle
    #2;
    check_reset_vals("rst");
    @(negedge clk);
    reset = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);

    // Fill to full, fifth push refused, then drain in order
    for (int i = 1; i <= 4; i++) step(1, 32'hA5A5_0000 + 32'(i), 0, 0);
    step(1, 32'hA5A5_0005, 0, 0);
    check("full_after_fill", 32'(full), 32'd1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    check("empty_after_drain", 32'(empty), 32'd1);

    // Streaming 16 entries
    for (int i = 0; i < 16; i++) step(1, 32'hC0DE_0000 + 32'(i), 1, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 1, 0);

    // Full with in_valid and out_ready both high
    for (int i = 0; i < 4; i++) step(1, 32'hF000_0000 + 32'(i), 0, 0);
    step(1, 32'hF000_0010, 1, 0);
    step(1, 32'hF000_0011, 1, 0);
    step(0, 0, 0, 0);
    check("full_pop_count", 32'(count), 32'd3);

    // Flush with concurrent push
    step(1, 32'hDEAD_0001, 0, 1);
    step(0, 0, 0, 0);
    check("flush_empty", 32'(empty), 32'd1);
    step(0, 0, 1, 0);

    // Bypass / one-cycle latency on empty
    step(1, 32'h0000_1234, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) step(1, $urandom, 0, 0);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("async_rst");
    q.delete();
    @(negedge clk);
    reset = 1'b1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), $urandom,
           1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
